// File: rtl/ninjin_ddr_sched_pkg.sv
// Shared types and constants for the ninjin DDR command scheduler and its arbiter.
package ninjin_ddr_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_XFER = 2'd2,
      ST_DONE = 2'd3
   } sched_state_t;

   localparam int DEF_NREQ   = 3;
   localparam int DEF_AWIDTH = 32;
   localparam int DEF_LWIDTH = 8;

   localparam int REQ_IMG = 0;
   localparam int REQ_WGT = 1;
   localparam int REQ_OUT = 2;

endpackage

// File: rtl/ninjin_ddr_sched_arb.sv
// Combinational round-robin pick: first requester above i_ptr (wrapping) wins.
module ninjin_rr_arbiter
   import ninjin_ddr_sched_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_gnt,
   output logic [IW-1:0]   o_idx,
   output logic            o_any
);

   int w_cand;

   always_comb begin
      o_gnt  = '0;
      o_idx  = '0;
      o_any  = 1'b0;
      w_cand = 0;
      for (int k = 1; k <= NREQ; k++) begin
         w_cand = (int'(i_ptr) + k) % NREQ;
         for (int j = 0; j < NREQ; j++) begin
            if (!o_any && (j == w_cand) && i_req[j]) begin
               o_any    = 1'b1;
               o_gnt[j] = 1'b1;
               o_idx    = IW'(j);
            end
         end
      end
   end

endmodule

// File: rtl/ninjin_ddr_sched.sv
// Round-robin scheduler for the shared kinpira DDR burst-command port.
// Optional watchdog on stalled CMD/XFER: define NINJIN_SCHED_TIMEOUT_EN.
module ninjin_ddr_sched
   import ninjin_ddr_sched_pkg::*;
#(
   parameter int NREQ    = DEF_NREQ,
   parameter int AWIDTH  = DEF_AWIDTH,
   parameter int LWIDTH  = DEF_LWIDTH,
   parameter int TIMEOUT = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ-1:0]        req_we,
   input  logic [NREQ*AWIDTH-1:0] req_addr,
   input  logic [NREQ*LWIDTH-1:0] req_len,
   output logic [NREQ-1:0]        grant,
   output logic [NREQ-1:0]        done,
   output logic                   ddr_cmd_valid,
   input  logic                   ddr_cmd_ready,
   output logic                   ddr_cmd_we,
   output logic [AWIDTH-1:0]      ddr_cmd_addr,
   output logic [LWIDTH-1:0]      ddr_cmd_len,
   input  logic                   ddr_beat,
   output logic                   busy,
   output logic                   err
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [LWIDTH:0] CNT_ONE = (LWIDTH+1)'(1);

   sched_state_t      r_state, w_next;
   logic [IW-1:0]     r_rr_ptr;
   logic [IW-1:0]     r_idx;
   logic [NREQ-1:0]   r_grant;
   logic              r_we;
   logic [AWIDTH-1:0] r_addr;
   logic [LWIDTH-1:0] r_len;
   logic [LWIDTH:0]   r_cnt;
   logic              r_err;

   logic [NREQ-1:0]   w_gnt;
   logic [IW-1:0]     w_idx;
   logic              w_any;
   logic              w_sel_we;
   logic [AWIDTH-1:0] w_sel_addr;
   logic [LWIDTH-1:0] w_sel_len;
   logic              w_last_beat;
   logic              w_tmo;

   ninjin_rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_arb (
      .i_req (req_valid),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   always_comb begin
      w_sel_we   = 1'b0;
      w_sel_addr = '0;
      w_sel_len  = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (w_gnt[k]) begin
            w_sel_we   = req_we[k];
            w_sel_addr = req_addr[k*AWIDTH +: AWIDTH];
            w_sel_len  = req_len[k*LWIDTH +: LWIDTH];
         end
      end
   end

   assign w_last_beat = (r_state == ST_XFER) && ddr_beat && (r_cnt == {1'b0, r_len});

`ifdef NINJIN_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] r_wdog;
   logic          w_wait;
   logic          w_prog;

   assign w_wait = (r_state == ST_CMD) || (r_state == ST_XFER);
   assign w_prog = ((r_state == ST_CMD) && ddr_cmd_ready) || ((r_state == ST_XFER) && ddr_beat);
   assign w_tmo  = w_wait && !w_prog && (r_wdog == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_wdog <= '0;
      else if (w_wait && !w_prog && !w_tmo)
         r_wdog <= r_wdog + TW'(1);
      else
         r_wdog <= '0;
   end
`else
   // Watchdog compiled out; TIMEOUT is only meaningful with the macro defined.
   assign w_tmo = (TIMEOUT < 0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_any) w_next = ST_CMD;
         ST_CMD: begin
            if (ddr_cmd_ready)  w_next = ST_XFER;
            else if (w_tmo)     w_next = ST_DONE;
         end
         ST_XFER: begin
            if (w_last_beat)    w_next = ST_DONE;
            else if (w_tmo)     w_next = ST_DONE;
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr <= IW'(NREQ - 1);
         r_idx    <= '0;
         r_grant  <= '0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_len    <= '0;
         r_cnt    <= '0;
         r_err    <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) && w_any) begin
            r_idx   <= w_idx;
            r_grant <= w_gnt;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_len   <= w_sel_len;
         end
         if ((r_state == ST_CMD) && ddr_cmd_ready)
            r_cnt <= '0;
         else if ((r_state == ST_XFER) && ddr_beat)
            r_cnt <= r_cnt + CNT_ONE;
         if (r_state == ST_DONE) begin
            r_rr_ptr <= r_idx;
            r_grant  <= '0;
         end
         // Beats outside XFER mean the DDR side and scheduler disagree.
         if ((ddr_beat && (r_state != ST_XFER)) || w_tmo)
            r_err <= 1'b1;
      end
   end

   assign req_ready     = (r_state == ST_IDLE) ? w_gnt : '0;
   assign grant         = r_grant;
   assign done          = (r_state == ST_DONE) ? r_grant : '0;
   assign ddr_cmd_valid = (r_state == ST_CMD);
   assign ddr_cmd_we    = r_we;
   assign ddr_cmd_addr  = r_addr;
   assign ddr_cmd_len   = r_len;
   assign busy          = (r_state != ST_IDLE);
   assign err           = r_err;

endmodule

// File: tb/tb_ninjin_ddr_sched.sv
// Scoreboard bench for ninjin_ddr_sched: stimulus pushes expected commands/dones, a monitor pops them.
module tb_ninjin_ddr_sched;
   import ninjin_ddr_sched_pkg::*;

   localparam int NREQ = 3;
   localparam int AW   = 32;
   localparam int LW   = 8;
   localparam int TMO  = 16;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   req_we;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*LW-1:0] req_len;
   logic [NREQ-1:0]   grant;
   logic [NREQ-1:0]   done;
   logic              ddr_cmd_valid;
   logic              ddr_cmd_ready;
   logic              ddr_cmd_we;
   logic [AW-1:0]     ddr_cmd_addr;
   logic [LW-1:0]     ddr_cmd_len;
   logic              ddr_beat;
   logic              busy;
   logic              err;

   ninjin_ddr_sched #(
      .NREQ    (NREQ),
      .AWIDTH  (AW),
      .LWIDTH  (LW),
      .TIMEOUT (TMO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_we        (req_we),
      .req_addr      (req_addr),
      .req_len       (req_len),
      .grant         (grant),
      .done          (done),
      .ddr_cmd_valid (ddr_cmd_valid),
      .ddr_cmd_ready (ddr_cmd_ready),
      .ddr_cmd_we    (ddr_cmd_we),
      .ddr_cmd_addr  (ddr_cmd_addr),
      .ddr_cmd_len   (ddr_cmd_len),
      .ddr_beat      (ddr_beat),
      .busy          (busy),
      .err           (err)
   );

   typedef struct {
      logic [AW-1:0]   addr;
      logic [LW-1:0]   len;
      logic            we;
      logic [NREQ-1:0] gnt;
   } cmd_t;

   cmd_t            cmd_q[$];
   logic [NREQ-1:0] done_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_done = -1;
   bit spacing_on = 0;
   bit auto_beat  = 1;
   bit man_beat   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Beat responder: beats every XFER cycle in auto mode, otherwise follows man_beat.
   initial begin
      ddr_beat = 1'b0;
      forever begin
         @(negedge clk);
         if (auto_beat)
            ddr_beat = busy && !ddr_cmd_valid && (done == '0);
         else
            ddr_beat = man_beat;
      end
   end

   // Monitor: compares every command handshake and done pulse against the scoreboard.
   initial begin
      cmd_t            e;
      logic [NREQ-1:0] d;
      forever begin
         @(negedge clk);
         if (!rst && ddr_cmd_valid && ddr_cmd_ready) begin
            if (cmd_q.size() == 0) chk("cmd_unexpected", 64'd1, 64'd0);
            else begin
               e = cmd_q.pop_front();
               chk("cmd_addr", 64'(ddr_cmd_addr), 64'(e.addr));
               chk("cmd_len", 64'(ddr_cmd_len), 64'(e.len));
               chk("cmd_we", 64'(ddr_cmd_we), 64'(e.we));
               chk("cmd_grant", 64'(grant), 64'(e.gnt));
            end
         end
         if (done != '0) begin
            if (done_q.size() == 0) chk("done_unexpected", 64'(done), 64'd0);
            else begin
               d = done_q.pop_front();
               chk("done_vec", 64'(done), 64'(d));
            end
            if (spacing_on && last_done >= 0) chk("done_spacing", 64'(cyc - last_done), 64'd4);
            last_done = cyc;
         end
      end
   end

   task automatic issue(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l,
                        input logic w, input bit exp_done);
      cmd_t e;
      req_addr[i*AW +: AW] = a;
      req_len[i*LW +: LW]  = l;
      req_we[i]            = w;
      req_valid[i]         = 1'b1;
      e.addr = a; e.len = l; e.we = w; e.gnt = NREQ'(1 << i);
      cmd_q.push_back(e);
      if (exp_done) done_q.push_back(NREQ'(1 << i));
   endtask

   task automatic wait_ready(input int i);
      bit ok = 0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (req_ready[i]) begin ok = 1; break; end
      end
      if (!ok) chk("ready_wait_expired", 64'd0, 64'd1);
   endtask

   task automatic wait_idle(input logic [NREQ-1:0] g, input bit check_grant);
      bit ok = 0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (!busy) begin ok = 1; break; end
         if (check_grant) chk("grant_hold", 64'(grant), 64'(g));
      end
      if (!ok) chk("idle_wait_expired", 64'd0, 64'd1);
   endtask

   task automatic run_one(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l, input logic w);
      @(posedge clk); #1;
      issue(i, a, l, w, 1);
      wait_ready(i);
      @(posedge clk); #1;
      req_valid[i] = 1'b0;
      wait_idle(NREQ'(1 << i), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      logic [NREQ-1:0] rr_exp [6];
      int hs;
      int n;
      rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_len = '0;
      ddr_cmd_ready = 1'b1;
      rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("idle_outputs", 64'({grant, busy, ddr_cmd_valid, done, err, req_ready}), 64'd0);
      end
      chk("reset_cmd_addr", 64'(ddr_cmd_addr), 64'd0);
      chk("reset_cmd_len", 64'(ddr_cmd_len), 64'd0);

      // All three requesters valid, single-beat bursts: strict 0,1,2 rotation.
      @(posedge clk); #1;
      last_done = -1; spacing_on = 1;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < NREQ; i++)
            issue(i, AW'(32'h100 * (i + 1)), 8'd0, 1'b0, 1);
      hs = 0;
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            chk("rr_order", 64'(req_ready), 64'(rr_exp[hs]));
            hs++;
            if (hs == 6) break;
         end
      end
      if (hs != 6) chk("rr_handshakes", 64'(hs), 64'd6);
      @(posedge clk); #1;
      req_valid = '0;
      wait_idle('0, 0);
      spacing_on = 0;

      run_one(REQ_WGT, 32'h1000_0000, 8'd3, 1'b0);

      // Command port stalled for 10 cycles.
      @(posedge clk); #1;
      ddr_cmd_ready = 1'b0;
      issue(REQ_IMG, 32'hA000_0040, 8'd1, 1'b1, 1);
      wait_ready(REQ_IMG);
      @(posedge clk); #1;
      req_valid[REQ_IMG] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("stall_cmd_valid", 64'(ddr_cmd_valid), 64'd1);
         chk("stall_cmd_addr", 64'(ddr_cmd_addr), 64'h0000_0000_A000_0040);
      end
      @(posedge clk); #1;
      ddr_cmd_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("xfer_after_ready", 64'({busy, ddr_cmd_valid}), 64'b10);
      wait_idle(3'b001, 1);

      // Asynchronous reset in the middle of a len-7 burst.
      auto_beat = 0; man_beat = 0;
      @(posedge clk); #1;
      issue(REQ_WGT, 32'h2000_0000, 8'd7, 1'b0, 0);
      wait_ready(REQ_WGT);
      @(posedge clk); #1;
      req_valid[REQ_WGT] = 1'b0;
      @(posedge clk); #1;
      man_beat = 1;
      @(posedge clk); #1;
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      chk("rst_outputs", 64'({grant, busy, ddr_cmd_valid, done, req_ready, err, ddr_cmd_we}), 64'd0);
      chk("rst_cmd_addr", 64'(ddr_cmd_addr), 64'd0);
      chk("rst_cmd_len", 64'(ddr_cmd_len), 64'd0);
      man_beat = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
         req_addr[i*AW +: AW] = AW'(32'h100 * (i + 1));
         req_len[i*LW +: LW]  = '0;
         req_we[i]            = 1'b0;
      end
      req_valid = 3'b111;
      begin
         cmd_t e;
         e.addr = 32'h100; e.len = 8'd0; e.we = 1'b0; e.gnt = 3'b001;
         cmd_q.push_back(e);
         done_q.push_back(3'b001);
      end
      @(negedge clk);
      chk("rr_after_reset", 64'(req_ready), 64'b001);
      @(posedge clk); #1;
      req_valid = '0;
      auto_beat = 1;
      wait_idle(3'b001, 1);

`ifdef NINJIN_SCHED_TIMEOUT_EN
      auto_beat = 0; man_beat = 0;
      @(negedge clk);
      chk("err_before_wdog", 64'(err), 64'd0);
      @(posedge clk); #1;
      issue(REQ_OUT, 32'h3000_0000, 8'd2, 1'b0, 1);
      wait_ready(REQ_OUT);
      @(posedge clk); #1;
      req_valid[REQ_OUT] = 1'b0;
      hs = 0;
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         if (done != '0) break;
         if (busy && !ddr_cmd_valid) hs++;
      end
      chk("wdog_cycles", 64'(hs), 64'(TMO));
      chk("wdog_err", 64'(err), 64'd1);
      wait_idle('0, 0);
`else
      @(negedge clk);
      chk("err_before_stray", 64'(err), 64'd0);
`endif

      // Stray beat while idle.
      auto_beat = 0;
      @(posedge clk); #1;
      man_beat = 1;
      @(posedge clk); #1;
      man_beat = 0;
      @(negedge clk);
      chk("stray_err", 64'(err), 64'd1);
      chk("stray_busy", 64'(busy), 64'd0);

      repeat (3) @(negedge clk);
      chk("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
      chk("done_q_drained", 64'(done_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
